// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_stage_reg slice: control states, occupancy width
// and the state-to-occupancy decode.
package pipe_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  function automatic logic [OCC_W-1:0] occ_of(input pipe_state_e st);
    case (st)
      EMPTY:   occ_of = 2'd0;
      HALF:    occ_of = 2'd1;
      FULL:    occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-bit payload register with load enable and asynchronous active-high reset to RESET_VAL.
module pipe_data_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  assign q_o = data_q;

  // Payload storage: reset value, load, or hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= RESET_VAL;
    end else if (load_i) begin
      data_q <= d_i;
    end else begin
      data_q <= data_q;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register. Defining PIPE_STAGE_SKID_EN adds a skid
// register and FULL state so in_ready is registered; otherwise in_ready is combinational.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [OCC_W-1:0] occ
);

  pipe_state_e      state_q;
  pipe_state_e      state_d;
  logic             out_valid_q;
  logic [OCC_W-1:0] occ_q;
  logic             push_s;
  logic             pop_s;
  logic             main_load_s;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_din_s;

`ifdef PIPE_STAGE_SKID_EN
  logic             skid_load_s;
  logic             main_from_skid_s;
  logic             in_ready_q;
  logic [WIDTH-1:0] skid_q;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occ       = occ_q;
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid_q && out_ready;

`ifdef PIPE_STAGE_SKID_EN
  assign in_ready   = in_ready_q;
  assign main_din_s = main_from_skid_s ? skid_q : in_data;
`else
  assign in_ready   = !reset && (!out_valid_q || out_ready);
  assign main_din_s = in_data;
`endif

  // Next-state and register load decode; flush overrides any push or pop.
  always_comb begin
    state_d     = state_q;
    main_load_s = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    skid_load_s      = 1'b0;
    main_from_skid_s = 1'b0;
`endif
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push_s) begin
            state_d     = HALF;
            main_load_s = 1'b1;
          end else begin
            state_d = EMPTY;
          end
        end
        HALF: begin
          if (push_s && pop_s) begin
            state_d     = HALF;
            main_load_s = 1'b1;
          end else if (push_s) begin
`ifdef PIPE_STAGE_SKID_EN
            state_d     = FULL;
            skid_load_s = 1'b1;
`else
            // in_ready is low here without a skid register, so this branch never fires
            state_d = HALF;
`endif
          end else if (pop_s) begin
            state_d = EMPTY;
          end else begin
            state_d = HALF;
          end
        end
        FULL: begin
`ifdef PIPE_STAGE_SKID_EN
          if (pop_s) begin
            state_d          = HALF;
            main_load_s      = 1'b1;
            main_from_skid_s = 1'b1;
          end else begin
            state_d = FULL;
          end
`else
          state_d = EMPTY;
`endif
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // Control state plus its registered decodes (out_valid, occ).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      occ_q       <= {OCC_W{1'b0}};
    end else begin
      state_q     <= state_d;
      out_valid_q <= (state_d != EMPTY);
      occ_q       <= occ_of(state_d);
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  // Registered in_ready: low only while both registers are occupied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ready_q <= 1'b0;
    end else begin
      in_ready_q <= (state_d != FULL);
    end
  end

  pipe_data_reg #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .load_i(skid_load_s),
    .d_i   (in_data),
    .q_o   (skid_q)
  );
`endif

  pipe_data_reg #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RESET_VAL)
  ) u_main (
    .clk   (clk),
    .reset (reset),
    .load_i(main_load_s),
    .d_i   (main_din_s),
    .q_o   (main_q)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: a bounded FIFO reference model (capacity 2 with
// PIPE_STAGE_SKID_EN, otherwise 1) checked every cycle under directed and random stimulus.
module tb_pipe_stage_reg;

  localparam int          WIDTH = 32;
  localparam logic [31:0] RVAL  = 32'h5A5A_0001;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [1:0]       occ;

  int          n_checks;
  int          n_fail;
  int          dut_pops;
  bit          last_push;
  bit          rdy_q;
  bit          watch3;
  bit          saw3;
  logic [31:0] q[$];
  logic [31:0] pop_log[$];

  pipe_stage_reg #(
    .WIDTH    (WIDTH),
    .RESET_VAL(RVAL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .occ      (occ)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_in_ready();
    if (reset) return 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    return rdy_q;
`else
    return (q.size() == 0) || out_ready;
`endif
  endfunction

  // One clock: check outputs at negedge, then update the model at posedge.
  task automatic step();
    bit push;
    bit pop;
    bit er;
    @(negedge clk);
    er = exp_in_ready();
    chk_val("out_valid", 128'(out_valid), 128'(q.size() != 0));
    chk_val("occ", 128'(occ), 128'(q.size()));
    chk_val("in_ready", 128'(in_ready), 128'(er));
    if (q.size() != 0) chk_val("out_data", 128'(out_data), 128'(q[0]));
    if (out_valid && out_ready) begin
      dut_pops++;
      pop_log.push_back(out_data);
    end
    if (watch3 && out_valid && (out_data == 32'h3)) saw3 = 1'b1;
    push = in_valid && er;
    pop  = (q.size() != 0) && out_ready;
    last_push = push;
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(in_data);
    end
    rdy_q = (q.size() < CAP);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    #1;
    chk_val("rst_out_valid", 128'(out_valid), 128'(0));
    chk_val("rst_out_data", 128'(out_data), 128'(RVAL));
    chk_val("rst_occ", 128'(occ), 128'(0));
    chk_val("rst_in_ready", 128'(in_ready), 128'(0));
    q.delete();
    rdy_q = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    #1 chk_val("rel_in_ready", 128'(in_ready), 128'(exp_in_ready()));
    @(posedge clk);
    rdy_q = 1'b1;
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (q.size() != 0) step();
    end
    chk_val("drain_done", 128'(out_valid), 128'(0));
  endtask

  initial begin
    logic [31:0] vals [3];
    int          idx;
    n_checks  = 0;
    n_fail    = 0;
    dut_pops  = 0;
    watch3    = 1'b0;
    saw3      = 1'b0;
    rdy_q     = 1'b0;
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;
    #2;
    do_reset();

    // single item, one-edge latency
    in_valid = 1'b1; in_data = 32'h0000_0011; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();

    // back-pressure and ordering
    vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC;
    idx = 0;
    out_ready = 1'b0;
    pop_log.delete();
    for (int c = 0; c < 10; c++) begin
      if (c == 5) out_ready = 1'b1;
      in_valid = (idx < 3);
      in_data  = (idx < 3) ? vals[idx] : 32'h0;
      step();
      if (last_push) idx++;
    end
    drain();
    chk_val("order_cnt", 128'(pop_log.size()), 128'(3));
    for (int i = 0; i < 3; i++) begin
      if (i < pop_log.size()) chk_val("order_val", 128'(pop_log[i]), 128'(vals[i]));
    end

    // 100-item stream at full rate
    dut_pops  = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = 32'h1000 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    chk_val("stream_pops", 128'(dut_pops), 128'(100));

    // fill, then flush with a simultaneous push of 0x3
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h1; step();
    in_data = 32'h2; step();
    watch3 = 1'b1;
    flush = 1'b1; in_data = 32'h3; step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    chk_val("flush_occ", 128'(occ), 128'(0));
    chk_val("flush_no3", 128'(saw3), 128'(0));
    watch3 = 1'b0;

    // reset in the middle of a held transfer
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h77; step();
    in_data = 32'h78; step();
    do_reset();

`ifndef PIPE_STAGE_SKID_EN
    // combinational in_ready follows out_ready while holding an item
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55; step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b0;
      #1 chk_val("rdy_follow0", 128'(in_ready), 128'(0));
      out_ready = 1'b1;
      #1 chk_val("rdy_follow1", 128'(in_ready), 128'(1));
      out_ready = 1'b0;
      in_valid  = 1'b1; in_data = 32'h60 + 32'(i);
      step();
      chk_val("occ_max1", 128'(occ <= 2'd1), 128'(1));
    end
    drain();
`endif

    // randomized traffic with occasional flush and one mid-run reset
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      step();
    end
    flush = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: payload width in bits, legal range 1..128.
REQ-002 The block SHALL have parameter RESET_VAL, default 0: WIDTH-bit value loaded into every data register on reset.
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port flush, input, 1 bit: synchronous squash of stage contents.
REQ-006 Port in_valid, input, 1 bit: upstream offers in_data.
REQ-007 Port in_data, input, WIDTH bits: upstream payload.
REQ-008 Port in_ready, output, 1 bit: stage accepts in_data this cycle.
REQ-009 Port out_valid, output, 1 bit: out_data holds a valid item.
REQ-010 Port out_data, output, WIDTH bits: downstream payload.
REQ-011 Port out_ready, input, 1 bit: downstream accepts out_data.
REQ-012 Port occ, output, 2 bits: number of items held (0..2).

Function
REQ-013 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-014 Control SHALL be a state machine with states EMPTY (occ=0), HALF (occ=1, main register full) and FULL (occ=2, main and skid registers full).
REQ-015 EMPTY: push SHALL move to HALF and load main; otherwise the stage SHALL remain in EMPTY.
REQ-016 HALF: push without pop SHALL move to FULL and load skid; push with pop SHALL stay in HALF and load main; pop alone SHALL move to EMPTY; otherwise the stage SHALL remain in HALF.
REQ-017 FULL: pop SHALL move to HALF and copy skid into main; otherwise the stage SHALL remain in FULL.
REQ-018 in_ready SHALL be a registered output: 1 in EMPTY and HALF, 0 in FULL; it SHALL NOT depend combinationally on out_ready.
REQ-019 out_valid SHALL be 1 exactly when the state is not EMPTY, and out_data SHALL always drive main.
REQ-020 Latency: an item pushed at edge N SHALL be visible on out_data after edge N when the stage was EMPTY, or when it was HALF and popped in the same cycle.
REQ-021 Items SHALL leave in push order, with no loss or duplication.
REQ-022 While out_valid && !out_ready, out_data SHALL hold stable.
REQ-023 flush SHALL take priority over push and pop: next state EMPTY, occ 0, and any same-cycle push discarded.
REQ-024 On flush, the data registers SHALL keep their values; out_valid SHALL go low on the next edge.
REQ-025 With back-to-back pushes and out_ready held at 1, the stage SHALL sustain one item per cycle.

Reset
REQ-026 While reset is high, the block SHALL force state EMPTY, out_valid=0, in_ready=0 and occ=0, and load main and skid with RESET_VAL, asynchronously.
REQ-027 At the first clk edge after reset deasserts, in_ready SHALL become 1.
REQ-028 Reset asserted mid-transfer SHALL discard all held items with no partial output.

Configuration
REQ-029 Macro PIPE_STAGE_SKID_EN defined: the skid register and FULL state SHALL be present, and behaviour SHALL be exactly as in REQ-014..REQ-025.
REQ-030 Macro PIPE_STAGE_SKID_EN undefined: there SHALL be no skid register and FULL SHALL be unreachable; in_ready SHALL equal (!out_valid || out_ready) combinationally (forced 0 during reset); occ SHALL max at 1; all other requirements SHALL still hold.

Structure
REQ-031 Shared package pipe_pkg SHALL hold the state typedef (EMPTY=2'd0, HALF=2'd1, FULL=2'd2) and the constant OCC_W=2.
REQ-032 Main and skid SHALL each be an instance of sub-module pipe_data_reg: a WIDTH-bit register with load enable, asynchronous active-high reset and a RESET_VAL parameter.

Verification
REQ-033 Reset release, then push 0x00000011 with out_ready=1 -> out_valid=1 and out_data=0x11 one edge later, occ=1 then 0.
REQ-034 Push 0xA, 0xB, 0xC on consecutive cycles with out_ready=0 -> occ=2 and in_ready=0 after 0xB; 0xC held upstream; raising out_ready -> output order 0xA, 0xB, 0xC.
REQ-035 Stream 100 items with out_ready=1 throughout -> one pop per cycle, no gaps after the first.
REQ-036 FULL state (0x1, 0x2), then flush with simultaneous push of 0x3 -> next cycle occ=0, out_valid=0, in_ready=1; 0x3 never appears at the output.
REQ-037 Reset pulse while occ=2 -> out_valid=0 and out_data=RESET_VAL immediately, without waiting for a clk edge.
REQ-038 PIPE_STAGE_SKID_EN undefined, out_ready toggling 1/0 -> in_ready follows out_ready combinationally whenever out_valid=1, and occ never exceeds 1.
